alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Sequences commands into the shared combinational 4-bit alu. Buffers opcode/operand
//  commands in a small FIFO, drives alu opcode/a/b one command at a time, captures c,
//  returns results over a valid/ready channel. Keeps an accumulator that can replace
//  operand a for chained arithmetic. Sits between the command source and alu.
// PARAMETERS
//  DATA_W   4  operand/result width; matches alu a/b/c
//  DEPTH    4  command FIFO entries, power of two, >=2
//  ALU_LAT  1  cycles operands are held on alu before c is sampled, >=1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       synchronous, active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when valid&ready; = !fifo_full
//  cmd_op       in   4       alu opcode (alu_pkg encoding, legal 1..OP_MAX=8)
//  cmd_a        in   DATA_W  operand a
//  cmd_b        in   DATA_W  operand b
//  cmd_use_acc  in   1       1: use accumulator in place of cmd_a
//  acc_clr      in   1       synchronous accumulator clear
//  alu_opcode   out  4       to alu.opcode; 0 outside EXEC
//  alu_a        out  DATA_W  to alu.a
//  alu_b        out  DATA_W  to alu.b
//  alu_c        in   DATA_W  from alu.c
//  res_valid    out  1       result available; held until res_ready
//  res_ready    in   1       result consumer ready
//  res_data     out  DATA_W  result
//  res_err      out  1       1: illegal opcode, res_data=0
//  acc_out      out  DATA_W  accumulator value
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE, all outputs 0 except cmd_ready=1. Reset mid-op
//   drops the in-flight command and all queued commands; no result emitted.
//  FIFO: push on cmd_valid&cmd_ready; no push when full even if popping same cycle.
//   In-order; pointers wrap mod DEPTH; count distinguishes full from empty.
//  FSM IDLE: FIFO non-empty -> pop head into operand regs (a := acc if use_acc,
//   sampled at pop). Legal op -> EXEC; op==0 or op>OP_MAX -> RESP, res_err=1, res_data=0.
//  FSM EXEC: alu_opcode/alu_a/alu_b driven from operand regs for ALU_LAT cycles; on the
//   last EXEC cycle edge res_data<=alu_c, res_err<=0, acc<=alu_c -> RESP.
//  FSM RESP: res_valid=1, res_data/res_err stable; on res_valid&res_ready -> IDLE.
//   No pop in the same cycle as the RESP handshake (one bubble per command).
//  Latency (ALU_LAT=1, empty/idle): accepted at edge E0, popped E1, res_valid from E2.
//  Accumulator: acc_clr has priority over capture in the same cycle; illegal ops never
//   modify acc. Result width DATA_W; alu carry/overflow not captured.
// CONFIGURATION
//  ALU_SEQ_STATS_EN defined: adds outputs stat_ops[15:0] (legal ops completed) and
//   stat_errs[15:0] (illegal ops), saturating at 16'hFFFF, cleared by reset only.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  alu_pkg: OP_* opcode constants, OP_MAX, seq_state_t enum {IDLE,EXEC,RESP},
//   cmd_t struct {op,a,b,use_acc}.
//  Sub-module alu_cmd_fifo (cmd_t entries, DEPTH); FSM, accumulator, result regs in top.
// TESTING
//  1 rst_n=0 two cycles -> cmd_ready=1, res_valid=0, acc_out=0, alu_opcode=0.
//  2 op=1(ADD) a=4 b=3, res_ready=1 -> res_valid 2 cycles after accept, res_data=7,
//    res_err=0, acc_out=7.
//  3 ADD 4+3 then op=2(SUB) use_acc=1 b=2 -> results 7 then 5 in order, acc_out=5.
//  4 res_ready=0, push 6 cmds (DEPTH=4) -> 5 accepted, cmd_ready=0 on 6th; raise
//    res_ready -> 5 results in issue order, then 6th accepted.
//  5 op=0 and op=9 -> res_err=1, res_data=0, acc unchanged, alu_opcode stays 0.
//  6 rst_n=0 during EXEC with 3 queued -> next cycle reset values, no stale results.
//  7 acc_clr coincident with capture -> acc_out=0; res_data still holds alu_c.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu command sequencer: opcode encoding,
// sequencer state and the queued command record.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;
  localparam logic [OP_W-1:0] OP_MAX = OP_SHR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             use_acc;
  } cmd_t;

  // Opcode 0 is reserved as "alu idle", so it is never a legal command.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command buffer for the alu sequencer; DEPTH must be a power of two
// so the read/write pointers wrap without extra compare logic.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands one at a time into the shared combinational alu and returns
// results over valid/ready. Optional counters enabled by ALU_SEQ_STATS_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clr,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic [DATA_W-1:0] acc_out
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_errs
`endif
);

  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t        state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [LAT_W-1:0]  lat_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_err_q;
  logic [DATA_W-1:0] acc_q;

  cmd_t              push_cmd;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              head_legal;
  logic              exec_last;

  always_comb begin
    push_cmd         = '0;
    push_cmd.op      = cmd_op;
    push_cmd.a       = cmd_a;
    push_cmd.b       = cmd_b;
    push_cmd.use_acc = cmd_use_acc;
  end

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_valid),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head_legal = op_is_legal(head.op);
  assign exec_last  = (state_q == EXEC) && (lat_q == LAT_W'(ALU_LAT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = head_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (exec_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The alu bus is quiet (all zero) except while a legal command is executing.
  always_comb begin
    cmd_ready  = !fifo_full;
    res_valid  = (state_q == RESP);
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (state_q == EXEC) begin
      alu_opcode = op_q;
      alu_a      = a_q;
      alu_b      = b_q;
    end
    res_data = res_data_q;
    res_err  = res_err_q;
    acc_out  = acc_q;
  end

  // Operand a is taken from the accumulator value present at pop time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lat_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else if (pop) begin
      op_q  <= head.op;
      a_q   <= head.use_acc ? acc_q : head.a;
      b_q   <= head.b;
      lat_q <= '0;
      if (!head_legal) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
    end else if (state_q == EXEC) begin
      if (exec_last) begin
        res_data_q <= alu_c;
        res_err_q  <= 1'b0;
      end else begin
        lat_q <= lat_q + LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (exec_last) begin
      acc_q <= alu_c;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      if (exec_last && (stat_ops_q != 16'hFFFF)) begin
        stat_ops_q <= stat_ops_q + 16'd1;
      end
      if (pop && !head_legal && (stat_errs_q != 16'hFFFF)) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed command sequences plus a
// result-queue model of the sequencer, with a combinational alu model attached.
module tb_alu_cmd_sequencer;

  localparam int DATA_W  = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       cmd_valid   = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op      = '0;
  logic [3:0] cmd_a       = '0;
  logic [3:0] cmd_b       = '0;
  logic       cmd_use_acc = 1'b0;
  logic       acc_clr     = 1'b0;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_c;
  logic       res_valid;
  logic       res_ready   = 1'b0;
  logic [3:0] res_data;
  logic       res_err;
  logic [3:0] acc_out;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .acc_clr     (acc_clr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .acc_out     (acc_out)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_errs   (stat_errs)
`endif
  );

  // Behaviour of the shared combinational alu the sequencer drives.
  function automatic logic [3:0] aluModel(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    case (op)
      4'd1:    return 4'(a + b);
      4'd2:    return 4'(a - b);
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd7:    return 4'(a << 1);
      4'd8:    return a >> 1;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_c = aluModel(alu_opcode, alu_a, alu_b);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       useAcc;
  } cmdRec_t;

  cmdRec_t    pending[$];
  logic [3:0] modelAcc  = '0;
  bit         modelLive = 1'b0;
  bit         resSeen   = 1'b0;
  bit         snapRst   = 1'b1;
  bit         snapPush  = 1'b0;
  bit         snapResHs = 1'b0;
  bit         snapClr   = 1'b0;
  cmdRec_t    snapCmd   = '0;

  // Inputs only change just after a rising edge, so a falling-edge snapshot tells
  // exactly what the following rising edge will see.
  always @(negedge clk) begin
    cmdRec_t    head;
    logic [3:0] aEff;
    logic [3:0] expData;
    logic       expErr;
    bit         clrNow;
    clrNow = 1'b0;
    if (snapRst) begin
      pending.delete();
      modelAcc  = '0;
      resSeen   = 1'b0;
      modelLive = 1'b1;
    end else begin
      if (snapResHs && (pending.size() > 0)) begin
        void'(pending.pop_front());
        resSeen = 1'b0;
      end
      if (snapPush) pending.push_back(snapCmd);
      clrNow = snapClr;
    end

    if (modelLive) begin
      if (res_valid && !resSeen) begin
        if (pending.size() == 0) begin
          checkOutput("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          head    = pending[0];
          aEff    = head.useAcc ? modelAcc : head.a;
          expErr  = (head.op == 4'd0) || (head.op > 4'd8);
          expData = expErr ? 4'd0 : aluModel(head.op, aEff, head.b);
          checkOutput("model_res_data", 32'(res_data), 32'(expData));
          checkOutput("model_res_err", 32'(res_err), 32'(expErr));
          if (!expErr) modelAcc = expData;
        end
        resSeen = 1'b1;
      end
      if (clrNow) modelAcc = '0;
      checkOutput("model_acc_out", 32'(acc_out), 32'(modelAcc));
      if (res_valid) checkOutput("model_alu_quiet_in_resp", 32'(alu_opcode), 32'd0);
    end

    snapRst   = !rst_n;
    snapPush  = cmd_valid && cmd_ready;
    snapCmd   = {cmd_op, cmd_a, cmd_b, cmd_use_acc};
    snapResHs = res_valid && res_ready;
    snapClr   = acc_clr;
  end

  // Called and returns just after a rising edge; the command is accepted on the
  // rising edge immediately before it returns.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic useAcc);
    int waitCycles = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = useAcc;
    @(negedge clk);
    while (!cmd_ready && (waitCycles < 200)) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [3:0] expData,
                            input logic expErr, input logic [3:0] expAcc);
    int waitCycles = 0;
    @(negedge clk);
    while (!res_valid && (waitCycles < 100)) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({name, "_valid"}, 32'(res_valid), 32'd1);
    checkOutput({name, "_data"}, 32'(res_data), 32'(expData));
    checkOutput({name, "_err"}, 32'(res_err), 32'(expErr));
    checkOutput({name, "_acc"}, 32'(acc_out), 32'(expAcc));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int waitCycles = 0;
    @(negedge clk);
    while (((pending.size() != 0) || res_valid) && (waitCycles < 300)) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("drain_pending", 32'(pending.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values.
    rst_n     = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t1_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t1_acc_out", 32'(acc_out), 32'd0);
    checkOutput("t1_alu_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ADD: accept E0, pop E1, result visible after E2.
    res_ready = 1'b1;
    applyStimulus(4'd1, 4'd4, 4'd3, 1'b0);
    @(negedge clk);
    checkOutput("t2_valid_after_accept", 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput("t2_valid_in_exec", 32'(res_valid), 32'd0);
    checkOutput("t2_alu_opcode", 32'(alu_opcode), 32'd1);
    checkOutput("t2_alu_a", 32'(alu_a), 32'd4);
    checkOutput("t2_alu_b", 32'(alu_b), 32'd3);
    @(negedge clk);
    checkOutput("t2_res_valid", 32'(res_valid), 32'd1);
    checkOutput("t2_res_data", 32'(res_data), 32'd7);
    checkOutput("t2_res_err", 32'(res_err), 32'd0);
    checkOutput("t2_acc_out", 32'(acc_out), 32'd7);
    @(posedge clk);
    #1;

    // Chained: 4+3, then acc-2.
    applyStimulus(4'd1, 4'd4, 4'd3, 1'b0);
    applyStimulus(4'd2, 4'd9, 4'd2, 1'b1);
    waitResult("t3_first", 4'd7, 1'b0, 4'd7);
    waitResult("t3_second", 4'd5, 1'b0, 4'd5);

    // Back-pressure: one in flight plus DEPTH queued, the sixth must wait.
    res_ready = 1'b0;
    applyStimulus(4'd1, 4'd1, 4'd1, 1'b0);
    applyStimulus(4'd2, 4'd9, 4'd2, 1'b0);
    applyStimulus(4'd3, 4'd12, 4'd10, 1'b0);
    applyStimulus(4'd4, 4'd5, 4'd2, 1'b0);
    applyStimulus(4'd5, 4'd15, 4'd5, 1'b0);
    cmd_valid   = 1'b1;
    cmd_op      = 4'd7;
    cmd_a       = 4'd3;
    cmd_b       = 4'd0;
    cmd_use_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_full_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    applyStimulus(4'd7, 4'd3, 4'd0, 1'b0);
    waitDrain();
    checkOutput("t4_final_acc", 32'(acc_out), 32'd6);

    // Illegal opcodes leave acc alone and never reach the alu.
    applyStimulus(4'd1, 4'd2, 4'd3, 1'b0);
    waitResult("t5_setup", 4'd5, 1'b0, 4'd5);
    applyStimulus(4'd0, 4'd7, 4'd7, 1'b0);
    waitResult("t5_op0", 4'd0, 1'b1, 4'd5);
    applyStimulus(4'd9, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    checkOutput("t5_op9_alu_idle_a", 32'(alu_opcode), 32'd0);
    checkOutput("t5_op9_not_yet", 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput("t5_op9_alu_idle_b", 32'(alu_opcode), 32'd0);
    checkOutput("t5_op9_valid", 32'(res_valid), 32'd1);
    checkOutput("t5_op9_err", 32'(res_err), 32'd1);
    checkOutput("t5_op9_data", 32'(res_data), 32'd0);
    checkOutput("t5_op9_acc", 32'(acc_out), 32'd5);
    @(posedge clk);
    #1;

    // Reset while executing with three commands still queued.
    res_ready = 1'b0;
    applyStimulus(4'd1, 4'd1, 4'd2, 1'b0);
    applyStimulus(4'd1, 4'd2, 4'd2, 1'b0);
    applyStimulus(4'd2, 4'd5, 4'd1, 1'b0);
    applyStimulus(4'd4, 4'd1, 4'd8, 1'b0);
    applyStimulus(4'd3, 4'd3, 4'd1, 1'b0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_exec_opcode", 32'(alu_opcode), 32'd1);
    checkOutput("t6_exec_a", 32'(alu_a), 32'd2);
    @(negedge clk);
    checkOutput("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t6_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t6_rst_acc_out", 32'(acc_out), 32'd0);
    checkOutput("t6_rst_alu_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t6_no_stale", 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Clear on the capture edge wins for acc but not for the result.
    applyStimulus(4'd1, 4'd4, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    @(negedge clk);
    checkOutput("t7_res_valid", 32'(res_valid), 32'd1);
    checkOutput("t7_res_data", 32'(res_data), 32'd7);
    checkOutput("t7_acc_out", 32'(acc_out), 32'd0);
    @(posedge clk);
    #1;

    waitDrain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
